// File: rtl/led_frame_scheduler.sv
// ---------------------------------------------------------------------------
// led_frame_scheduler
//
// Shares a 6x6 LED matrix between two frame sources. Each source offers a
// 36-bit image and a dwell time in display frames. A round-robin arbiter
// accepts one request at a time into a single-entry shadow register. The
// shadow moves onto the matrix image bus only on a frame boundary
// (frame_tick), so the scanner never shows a torn frame.
//
// Parameters:
//   DUR_W          width of the dwell inputs and of the internal dwell counter
//   BLANK_ON_IDLE  1: blank the image when a dwell expires with nothing queued
//                  0: keep showing the last image
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   frame_tick  one-cycle pulse per completed matrix scan
//   req_valid   per-source request valid (bit i = source i)
//   req_img0/1  source images, row r in bits [6r+5:6r]
//   req_dur0/1  source dwell in frames (0 is treated as 1)
//   req_ready   per-source accept (combinational)
//   img         registered image to the matrix scanner
//   active_id   source id of the image on img
//   busy        high while a dwell is running
//   frame_done  one-cycle pulse when a dwell expires
// ---------------------------------------------------------------------------
module led_frame_scheduler #(
    parameter int unsigned DUR_W         = 8,
    parameter bit          BLANK_ON_IDLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic [1:0]       req_valid,
    input  logic [35:0]      req_img0,
    input  logic [35:0]      req_img1,
    input  logic [DUR_W-1:0] req_dur0,
    input  logic [DUR_W-1:0] req_dur1,
    output logic [1:0]       req_ready,
    output logic [35:0]      img,
    output logic             active_id,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

    // Shadow (one-entry queue)
    logic             shadow_valid_q, shadow_valid_d;
    logic [35:0]      shadow_img_q,   shadow_img_d;
    logic [DUR_W-1:0] shadow_dur_q,   shadow_dur_d;
    logic             shadow_id_q,    shadow_id_d;

    // Arbitration history; reset to 1 so source 0 wins the first tie
    logic             last_grant_q,   last_grant_d;

    // Display side
    logic [DUR_W-1:0] cnt_q,          cnt_d;
    logic [35:0]      img_q,          img_d;
    logic             active_id_q,    active_id_d;
    logic             busy_q,         busy_d;
    logic             frame_done_q,   frame_done_d;

    // Transfer decode
    logic             xfer;
    logic             xfer_id;
    logic [35:0]      xfer_img;
    logic [DUR_W-1:0] xfer_dur_raw;
    logic [DUR_W-1:0] xfer_dur;
    logic             cnt_is_one;

    // Round-robin arbiter. Ready depends on the registered shadow state only,
    // so a slot freed by a tick load re-opens on the following cycle.
    always_comb begin
        req_ready = 2'b00;
        if (!shadow_valid_q) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = last_grant_q ? 2'b01 : 2'b10;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign xfer         = |(req_valid & req_ready);
    assign xfer_id      = req_ready[1];
    assign xfer_img     = xfer_id ? req_img1 : req_img0;
    assign xfer_dur_raw = xfer_id ? req_dur1 : req_dur0;
    // A zero dwell would never expire through the cnt==1 path; clamp to 1.
    assign xfer_dur     = (xfer_dur_raw == '0) ? DUR_ONE : xfer_dur_raw;
    assign cnt_is_one   = (cnt_q == DUR_ONE);

    always_comb begin
        shadow_valid_d = shadow_valid_q;
        shadow_img_d   = shadow_img_q;
        shadow_dur_d   = shadow_dur_q;
        shadow_id_d    = shadow_id_q;
        last_grant_d   = last_grant_q;
        cnt_d          = cnt_q;
        img_d          = img_q;
        active_id_d    = active_id_q;

        // Frame boundary handling. The tick looks at the registered shadow
        // only, so an entry accepted in the same cycle waits for the next tick.
        if (frame_tick) begin
            if (cnt_q > DUR_ONE) begin
                cnt_d = cnt_q - DUR_ONE;
            end else if (shadow_valid_q) begin
                img_d          = shadow_img_q;
                active_id_d    = shadow_id_q;
                cnt_d          = shadow_dur_q;
                shadow_valid_d = 1'b0;
            end else if (cnt_is_one) begin
                cnt_d = '0;
                if (BLANK_ON_IDLE) begin
                    img_d = '0;
                end
            end
        end

        // A transfer needs an empty shadow, so it can never coincide with the
        // tick load above that empties it.
        if (xfer) begin
            shadow_valid_d = 1'b1;
            shadow_img_d   = xfer_img;
            shadow_dur_d   = xfer_dur;
            shadow_id_d    = xfer_id;
            last_grant_d   = xfer_id;
        end

        frame_done_d = frame_tick && cnt_is_one;
        busy_d       = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_valid_q <= 1'b0;
            shadow_img_q   <= '0;
            shadow_dur_q   <= '0;
            shadow_id_q    <= 1'b0;
            last_grant_q   <= 1'b1;
            cnt_q          <= '0;
            img_q          <= '0;
            active_id_q    <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            shadow_valid_q <= shadow_valid_d;
            shadow_img_q   <= shadow_img_d;
            shadow_dur_q   <= shadow_dur_d;
            shadow_id_q    <= shadow_id_d;
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
            img_q          <= img_d;
            active_id_q    <= active_id_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign img        = img_q;
    assign active_id  = active_id_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_led_frame_scheduler
//
// Directed testbench for led_frame_scheduler. Two instances share stimulus:
// u_dut blanks on idle, u_hold keeps the last image. Inputs change 1 ns after
// the rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_led_frame_scheduler;

    localparam int DUR_W = 8;

    localparam logic [35:0] IMG_A = 36'h0_0000_003F;
    localparam logic [35:0] IMG_B = 36'hF_C000_0000;
    localparam logic [35:0] IMG_C = 36'h1_2345_6789;
    localparam logic [35:0] IMG_D = 36'hA_BCDE_F012;
    localparam logic [35:0] IMG_E = 36'h5_5555_5555;
    localparam logic [35:0] IMG_F = 36'hA_AAAA_AAAA;
    localparam logic [35:0] IMG_G = 36'h3_0303_0303;
    localparam logic [35:0] IMG_I = 36'h8_0000_0001;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             frame_tick;
    logic [1:0]       req_valid;
    logic [35:0]      req_img0, req_img1;
    logic [DUR_W-1:0] req_dur0, req_dur1;

    logic [1:0]  req_ready, ready_h;
    logic [35:0] img, img_h;
    logic        active_id, active_h;
    logic        busy, busy_h;
    logic        frame_done, fd_h;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_frame_scheduler #(.DUR_W(DUR_W), .BLANK_ON_IDLE(1'b1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .req_valid  (req_valid),
        .req_img0   (req_img0),
        .req_img1   (req_img1),
        .req_dur0   (req_dur0),
        .req_dur1   (req_dur1),
        .req_ready  (req_ready),
        .img        (img),
        .active_id  (active_id),
        .busy       (busy),
        .frame_done (frame_done)
    );

    led_frame_scheduler #(.DUR_W(DUR_W), .BLANK_ON_IDLE(1'b0)) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .req_valid  (req_valid),
        .req_img0   (req_img0),
        .req_img1   (req_img1),
        .req_dur0   (req_dur0),
        .req_dur1   (req_dur1),
        .req_ready  (ready_h),
        .img        (img_h),
        .active_id  (active_h),
        .busy       (busy_h),
        .frame_done (fd_h)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given frame_tick value; returns 1 ns after the edge.
    task automatic cyc(input logic tick);
        frame_tick = tick;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        $display("t=%0t tick=%0b valid=%b ready=%b img=%h id=%0b busy=%0b done=%0b",
                 $time, tick, req_valid, req_ready, img, active_id, busy, frame_done);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        req_valid  = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_img0 = '0;
        req_img1 = '0;
        req_dur0 = '0;
        req_dur1 = '0;

        // ---------------- reset state ----------------
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        req_valid  = 2'b00;
        @(posedge clk);
        #1;
        chk("rst_img",   img,        36'h0);
        chk("rst_id",    active_id,  1'b0);
        chk("rst_busy",  busy,       1'b0);
        chk("rst_done",  frame_done, 1'b0);
        chk("rst_ready", req_ready,  2'b00);
        rst_n = 1'b1;

        // ---------------- single request, dur=3 ----------------
        req_valid = 2'b01; req_img0 = IMG_A; req_dur0 = 8'd3;
        #1;
        chk("t1_ready0", req_ready, 2'b01);
        cyc(1'b0);                               // transfer
        chk("t1_ready_full", req_ready, 2'b00);
        req_valid = 2'b00;
        chk("t1_img_before", img, 36'h0);
        cyc(1'b1);                               // load
        chk("t1_img_load", img, IMG_A);
        chk("t1_busy_load", busy, 1'b1);
        chk("t1_done_load", frame_done, 1'b0);
        cyc(1'b1);
        chk("t1_img_k2", img, IMG_A);
        chk("t1_done_k2", frame_done, 1'b0);
        cyc(1'b1);
        chk("t1_img_k3", img, IMG_A);
        chk("t1_done_k3", frame_done, 1'b0);
        cyc(1'b1);                               // expiry
        chk("t1_done_exp", frame_done, 1'b1);
        chk("t1_img_blank", img, 36'h0);
        chk("t1_busy_exp", busy, 1'b0);
        cyc(1'b0);
        chk("t1_done_drop", frame_done, 1'b0);

        // ---------------- both valid, dur=1, alternating ----------------
        do_reset();
        req_valid = 2'b11;
        req_img0 = IMG_A; req_dur0 = 8'd1;
        req_img1 = IMG_B; req_dur1 = 8'd1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t2_grant%0d", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            cyc(1'b0);
            chk($sformatf("t2_full%0d", k), req_ready, 2'b00);
            cyc(1'b1);
            chk($sformatf("t2_id%0d", k), active_id, (k % 2 == 0) ? 1'b0 : 1'b1);
            chk($sformatf("t2_img%0d", k), img, (k % 2 == 0) ? IMG_A : IMG_B);
            chk($sformatf("t2_done%0d", k), frame_done, (k > 0) ? 1'b1 : 1'b0);
        end
        req_valid = 2'b00;
        cyc(1'b1);
        chk("t2_done_last", frame_done, 1'b1);
        chk("t2_img_last", img, 36'h0);

        // ---------------- long dwell with queued replacement ----------------
        do_reset();
        req_valid = 2'b10; req_img1 = IMG_C; req_dur1 = 8'd5;
        cyc(1'b0);
        req_valid = 2'b00;
        cyc(1'b1);                               // tick 0: load, cnt=5
        chk("t3_img_t0", img, IMG_C);
        chk("t3_id_t0", active_id, 1'b1);
        cyc(1'b1);                               // tick 1
        req_valid = 2'b01; req_img0 = IMG_D; req_dur0 = 8'd2;
        #1;
        chk("t3_ready_t2", req_ready, 2'b01);
        cyc(1'b1);                               // tick 2 + transfer
        req_valid = 2'b00;
        chk("t3_img_t2", img, IMG_C);
        req_valid = 2'b01;                       // hold valid to observe blocked ready
        #1;
        chk("t3_blocked_t2", req_ready, 2'b00);
        req_valid = 2'b00;
        cyc(1'b1);                               // tick 3
        chk("t3_img_t3", img, IMG_C);
        cyc(1'b1);                               // tick 4
        chk("t3_img_t4", img, IMG_C);
        chk("t3_done_t4", frame_done, 1'b0);
        cyc(1'b1);                               // tick 5: swap, no blank
        chk("t3_img_t5", img, IMG_D);
        chk("t3_id_t5", active_id, 1'b0);
        chk("t3_done_t5", frame_done, 1'b1);
        chk("t3_busy_t5", busy, 1'b1);

        // ---------------- transfer coincident with tick, then dur=0 --------
        do_reset();
        req_valid = 2'b01; req_img0 = IMG_E; req_dur0 = 8'd1;
        cyc(1'b1);                               // transfer + tick together
        req_valid = 2'b00;
        chk("t4_img_same", img, 36'h0);
        chk("t4_busy_same", busy, 1'b0);
        cyc(1'b0);
        chk("t4_img_wait", img, 36'h0);
        cyc(1'b1);
        chk("t4_img_load", img, IMG_E);
        req_valid = 2'b10; req_img1 = IMG_F; req_dur1 = 8'd0;
        cyc(1'b0);
        req_valid = 2'b00;
        cyc(1'b1);                               // E expires, F loads
        chk("t5_img_load", img, IMG_F);
        chk("t5_done_load", frame_done, 1'b1);
        chk("t5_busy_load", busy, 1'b1);
        cyc(1'b1);                               // dur 0 -> one tick
        chk("t5_done_exp", frame_done, 1'b1);
        chk("t5_img_exp", img, 36'h0);
        chk("t5_busy_exp", busy, 1'b0);

        // ---------------- reset mid-dwell with full shadow ----------------
        do_reset();
        req_valid = 2'b01; req_img0 = IMG_G; req_dur0 = 8'd5;
        cyc(1'b0);
        req_valid = 2'b00;
        cyc(1'b1);                               // cnt=5
        cyc(1'b1);                               // cnt=4
        req_valid = 2'b10; req_img1 = IMG_B; req_dur1 = 8'd2;
        cyc(1'b0);                               // shadow full
        req_valid = 2'b11;
        #1;
        chk("t6_full_pre", req_ready, 2'b00);
        chk("t6_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_img_rst", img, 36'h0);
        chk("t6_busy_rst", busy, 1'b0);
        chk("t6_ready_rst", req_ready, 2'b01);
        frame_tick = 1'b1;                       // ignored under reset
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        rst_n = 1'b1;
        chk("t6_done_rst", frame_done, 1'b0);
        chk("t6_busy_rel", busy, 1'b0);
        cyc(1'b0);                               // transfer to source 0
        chk("t6_done_rel", frame_done, 1'b0);
        chk("t6_full_rel", req_ready, 2'b00);
        req_valid = 2'b00;
        cyc(1'b1);
        chk("t6_id_load", active_id, 1'b0);
        chk("t6_img_load", img, IMG_G);

        // ---------------- BLANK_ON_IDLE=0 hold ----------------
        do_reset();
        req_valid = 2'b01; req_img0 = IMG_I; req_dur0 = 8'd2;
        cyc(1'b0);
        req_valid = 2'b00;
        cyc(1'b1);
        chk("t7_hold_load", img_h, IMG_I);
        cyc(1'b1);
        cyc(1'b1);                               // expiry
        chk("t7_hold_img", img_h, IMG_I);
        chk("t7_hold_busy", busy_h, 1'b0);
        chk("t7_hold_done", fd_h, 1'b1);
        chk("t7_blank_img", img, 36'h0);
        cyc(1'b0);
        chk("t7_hold_img2", img_h, IMG_I);
        chk("t7_hold_done2", fd_h, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
- Shares the 6x6 LED matrix between two frame sources, e.g. a status source and an animation source.
- Each source offers a 36-bit image plus a dwell time counted in display frames.
- Winners are picked round-robin and buffered in a one-entry shadow register.
- The shadow image moves to the matrix image bus only on a frame boundary, so the display never tears mid-scan. The image bus drives the matrix scanner; frame_tick comes from the scanner's row-wrap pulse.

Parameters:
DUR_W, 8, width of dwell-count inputs and internal dwell counter
BLANK_ON_IDLE, 1, 1 = drive img to all-zero when the dwell expires with nothing pending; 0 = hold the last image

Ports:
clk  input  1  system clock, single clock domain
rst_n  input  1  reset, asynchronous assert, active-low
frame_tick  input  1  one-cycle pulse per completed matrix scan (row index wrap)
req_valid  input  2  per-source request valid; bit i = source i
req_img0  input  36  source 0 image, row r in bits [6r+5:6r]
req_img1  input  36  source 1 image, same layout
req_dur0  input  DUR_W  source 0 dwell in frames
req_dur1  input  DUR_W  source 1 dwell in frames
req_ready  output  2  per-source accept; transfer occurs when req_valid[i] and req_ready[i] are both high on a clk edge
img  output  36  image to the matrix scanner (registered)
active_id  output  1  source id of the image currently on img
busy  output  1  high while a dwell is running (dwell counter != 0)
frame_done  output  1  one-cycle pulse when a displayed frame's dwell expires

Behaviour:
- Reset (async, rst_n=0) values:
  - img=0, active_id=0, busy=0, frame_done=0.
  - Shadow empty, shadow image=0, shadow dur=0, shadow id=0.
  - Dwell counter=0.
  - last_grant=1, so source 0 wins first.
- Reset mid-dwell drops the shadow and the displayed image immediately; no frame_done pulse.
- Arbitration is combinational from req_valid, last_grant and shadow_valid:
  - If the shadow is full, req_ready=00.
  - Otherwise, if only one source is valid, it gets ready.
  - If both are valid, the source != last_grant gets ready.
  - If no source is valid, req_ready=00.
- req_ready never asserts for a source whose valid is low.
- On transfer: shadow <= {img, max(dur,1), id}, shadow_valid<=1, last_grant<=id. Sources must hold their data stable while valid and not ready.
- Dwell counter cnt (DUR_W bits) acts only on cycles with frame_tick=1:
  - cnt>1: cnt<=cnt-1.
  - cnt==1 or cnt==0 with shadow full: img<=shadow image, active_id<=shadow id, cnt<=shadow dur, shadow_valid<=0.
  - cnt==1 with shadow empty: cnt<=0. img<=0 if BLANK_ON_IDLE=1, otherwise img holds.
  - cnt==0 with shadow empty: no change.
- frame_done is registered and pulses for exactly one cycle on every tick where cnt==1, whether or not a replacement loads.
- A transfer in the same cycle as a tick: shadow_valid was 0 for that cycle, so the tick sees no shadow. The new entry waits for the next tick; no same-cycle bypass into img.
- Shadow load on a tick makes req_ready go high again the following cycle if a source is valid.
- Latency: a request accepted into an idle scheduler reaches img on the first frame_tick strictly after the transfer edge. img is updated on that tick's clock edge.
- Dur=0 is treated as 1. Max dwell is 2^DUR_W-1 frames; the counter never wraps.
- frame_tick is ignored for a cycle where rst_n is low.
- busy = (cnt != 0), registered.

Test Plan:
- Reset, then source 0 valid with img=36'h0000_0003F, dur=3:
  - ready0 high for one cycle.
  - img changes on the next frame_tick.
  - img held for 3 ticks; frame_done pulses on the 3rd.
  - img=0 afterwards (BLANK_ON_IDLE=1), busy=0.
- Both sources valid and held continuously, each dur=1:
  - Grants alternate 0,1,0,1.
  - active_id toggles every tick.
  - frame_done pulses on every tick after the first load.
- Source 1 dur=5 displaying, source 0 submits at tick 2:
  - Shadow fills and req_ready=00 until tick 5.
  - At tick 5, img switches to the source 0 image and frame_done pulses.
  - No blank cycle occurs between the two images.
- Transfer in the same cycle as frame_tick while idle: img unchanged at that tick, loads at the following tick.
- dur=0 request: displayed for exactly 1 tick, frame_done pulses on that tick.
- rst_n low mid-dwell (cnt=4, shadow full):
  - img=0, busy=0 and req_ready reflects an empty shadow asynchronously.
  - After release, the next request is granted to source 0.
  - No frame_done pulse.
- BLANK_ON_IDLE=0: after dwell expiry with no pending request, img holds the last image and busy=0.
